// File: rtl/mul_cell_seq.sv
// Sequencer and combine stage for the 3-partial-product multiplier cell:
// launches one operand pair, then folds p1/p2/p3 into the low 32 product bits.
module mul_cell_seq #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_src1,
  input  logic [31:0]        in_src2,
  output logic [31:0]        cell_src1,
  output logic [31:0]        cell_src2,
  output logic               cell_en,
  input  logic [31:0]        cell_p1,
  input  logic [31:0]        cell_p2,
  input  logic [31:0]        cell_p3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_result,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    SUM    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state_q;
  logic [31:0]          src1_q;
  logic [31:0]          src2_q;
  logic [31:0]          result_q;
  logic                 cell_en_q;
  logic                 out_valid_q;
  logic [COUNT_W-1:0]   count_q;

  logic [15:0]          mid_d;
  logic [31:0]          result_d;
  logic                 unused_hi;

  // Cross products only reach bits [31:16], so their upper halves never matter.
  always_comb begin
    mid_d    = cell_p2[15:0] + cell_p3[15:0];
    result_d = cell_p1 + {mid_d, 16'h0000};
  end

  assign unused_hi = ^{cell_p2[31:16], cell_p3[31:16]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      src1_q      <= '0;
      src2_q      <= '0;
      result_q    <= '0;
      cell_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      cell_en_q <= 1'b0;
      if (flush) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_valid) begin
              src1_q    <= in_src1;
              src2_q    <= in_src2;
              cell_en_q <= 1'b1;
              state_q   <= LAUNCH;
            end
          end
          LAUNCH: state_q <= SUM;
          SUM: begin
            result_q    <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
          DONE: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              count_q     <= count_q + COUNT_W'(1);
              state_q     <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready   = (state_q == IDLE) && reset_n;
  assign cell_src1  = src1_q;
  assign cell_src2  = src2_q;
  assign cell_en    = cell_en_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_mul_cell_seq.sv
// Directed bench for mul_cell_seq with a registered behavioural multiplier cell.
module tb_mul_cell_seq;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_src1 = '0;
  logic [31:0]   in_src2 = '0;
  logic [31:0]   cell_src1;
  logic [31:0]   cell_src2;
  logic          cell_en;
  logic [31:0]   cell_p1 = '0;
  logic [31:0]   cell_p2 = '0;
  logic [31:0]   cell_p3 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_result;
  logic [CW-1:0] op_count;

  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [31:0]   last_result = '0;

  mul_cell_seq #(.COUNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2),
    .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural cell: products registered on the enabled edge.
  always @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
      cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
      cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Full transaction: accept, LAUNCH, SUM, DONE, handshake out.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    chk({name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_src1 = a; in_src2 = b;
    step();
    in_valid = 1'b0;
    chk({name, ".cell_en_launch"}, 32'(cell_en), 32'd1);
    chk({name, ".cell_src1"}, cell_src1, a);
    chk({name, ".cell_src2"}, cell_src2, b);
    chk({name, ".in_ready_launch"}, 32'(in_ready), 32'd0);
    step();
    chk({name, ".cell_en_sum"}, 32'(cell_en), 32'd0);
    chk({name, ".out_valid_sum"}, 32'(out_valid), 32'd0);
    step();
    chk({name, ".out_valid_done"}, 32'(out_valid), 32'd1);
    chk({name, ".out_result"}, out_result, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    last_result = exp;
    chk({name, ".out_valid_after"}, 32'(out_valid), 32'd0);
    chk({name, ".op_count"}, 32'(op_count), 32'(exp_cnt));
    $display("[TB] %s: 0x%08h * 0x%08h -> 0x%08h count=%0d", name, a, b, out_result, op_count);
  endtask

  task automatic test_reset();
    #2;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.cell_en", 32'(cell_en), 32'd0);
    chk("reset.out_result", out_result, 32'd0);
    chk("reset.op_count", 32'(op_count), 32'd0);
    chk("reset.cell_src1", cell_src1, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    $display("[TB] reset released, in_ready=%0b", in_ready);
  endtask

  task automatic test_arith();
    run_op("basic", 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
    run_op("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("signed", 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB);
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_src1 = 32'h0000_0064; in_src2 = 32'h0000_0003;
    step();
    in_valid = 1'b0;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; in_src1 = 32'hDEAD_0000 + 32'(i); in_src2 = 32'h1234_5678;
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.out_result", out_result, 32'h0000_012C);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.cell_src1", cell_src1, 32'h0000_0064);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 1'b1;
    last_result = 32'h0000_012C;
    chk("bp.in_ready_after", 32'(in_ready), 32'd1);
    chk("bp.out_valid_after", 32'(out_valid), 32'd0);
    chk("bp.op_count", 32'(op_count), 32'(exp_cnt));
    step();
    out_ready = 1'b0;
    chk("bp.op_count_once", 32'(op_count), 32'(exp_cnt));
    $display("[TB] backpressure: result=0x%08h count=%0d", out_result, op_count);
  endtask

  task automatic test_flush();
    // Flush while in SUM.
    in_valid = 1'b1; in_src1 = 32'h0000_0002; in_src2 = 32'h0000_0009;
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_sum.out_valid", 32'(out_valid), 32'd0);
    chk("flush_sum.in_ready", 32'(in_ready), 32'd1);
    chk("flush_sum.op_count", 32'(op_count), 32'(exp_cnt));
    chk("flush_sum.out_result", out_result, last_result);
    step();
    chk("flush_sum.no_valid", 32'(out_valid), 32'd0);
    // Flush while in DONE.
    in_valid = 1'b1; in_src1 = 32'h0000_0004; in_src2 = 32'h0000_0005;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("flush_done.out_valid_pre", 32'(out_valid), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_done.out_valid", 32'(out_valid), 32'd0);
    chk("flush_done.in_ready", 32'(in_ready), 32'd1);
    chk("flush_done.op_count", 32'(op_count), 32'(exp_cnt));
    run_op("post_flush", 32'h0000_0006, 32'h0000_0007, 32'h0000_002A);
    // Flush with a request in IDLE: request is dropped.
    flush = 1'b1; in_valid = 1'b1; in_src1 = 32'hAAAA_AAAA; in_src2 = 32'h5555_5555;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle.in_ready", 32'(in_ready), 32'd1);
    chk("flush_idle.cell_en", 32'(cell_en), 32'd0);
    chk("flush_idle.cell_src1", cell_src1, 32'h0000_0006);
    step(); step();
    chk("flush_idle.out_valid", 32'(out_valid), 32'd0);
    $display("[TB] flush scenarios done, count=%0d", op_count);
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_src1 = 32'h0000_0003; in_src2 = 32'h0000_0003;
    step();
    in_valid = 1'b0;
    chk("areset.cell_en_pre", 32'(cell_en), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset.cell_en", 32'(cell_en), 32'd0);
    chk("areset.out_valid", 32'(out_valid), 32'd0);
    chk("areset.op_count", 32'(op_count), 32'd0);
    chk("areset.out_result", out_result, 32'd0);
    chk("areset.cell_src1", cell_src1, 32'd0);
    exp_cnt = '0;
    last_result = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("areset.no_residual_valid", 32'(out_valid), 32'd0);
    end
    chk("areset.in_ready", 32'(in_ready), 32'd1);
    $display("[TB] async reset during LAUNCH, count=%0d", op_count);
  endtask

  task automatic test_count_wrap();
    run_op("cw1", 32'h0000_0002, 32'h0000_0003, 32'h0000_0006);
    run_op("cw2", 32'h0001_0000, 32'h0000_0003, 32'h0003_0000);
    run_op("cw3", 32'h1234_5678, 32'h0000_0001, 32'h1234_5678);
    run_op("cw4", 32'h0000_0100, 32'h0000_0100, 32'h0001_0000);
    run_op("cw5", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    chk("count_wrap.op_count", 32'(op_count), 32'd1);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
